alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle execute sequencer around the core ALU.
// Single-cycle ops finish in one clock. Shifts iterate one bit per cycle,
// so the datapath needs no barrel shifter. Uses a valid/ready request and
// response handshake.
module alu_seq_ctrl #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          alufn,
    input  logic [XLEN-1:0]     op_a,
    input  logic [XLEN-1:0]     op_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     result,
    output logic                zero,
    output logic                busy
);

    localparam logic [3:0] FN_ADD  = 4'b0000;
    localparam logic [3:0] FN_SUB  = 4'b0001;
    localparam logic [3:0] FN_PASS = 4'b0011;
    localparam logic [3:0] FN_OR   = 4'b0100;
    localparam logic [3:0] FN_AND  = 4'b0101;
    localparam logic [3:0] FN_XOR  = 4'b0111;
    localparam logic [3:0] FN_SLL  = 4'b1000;
    localparam logic [3:0] FN_SRL  = 4'b1001;
    localparam logic [3:0] FN_SRA  = 4'b1010;
    localparam logic [3:0] FN_SLT  = 4'b1101;
    localparam logic [3:0] FN_SLTU = 4'b1111;

    // Low two bits of the shift opcodes, kept as the latched shift type
    localparam logic [1:0] ST_SLL = 2'b00;
    localparam logic [1:0] ST_SRL = 2'b01;
    localparam logic [1:0] ST_SRA = 2'b10;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state;
    logic [XLEN-1:0]      acc;
    logic [SHAMT_W-1:0]   cnt;
    logic [1:0]           styp;

    logic                 is_shift;
    logic [SHAMT_W-1:0]   shamt;
    logic [XLEN-1:0]      alu_f;
    logic [XLEN-1:0]      acc_nxt;

    assign shamt    = op_b[SHAMT_W-1:0];
    assign is_shift = (alufn == FN_SLL) || (alufn == FN_SRL) || (alufn == FN_SRA);

    // Single-cycle function set; unlisted codes produce zero
    always_comb begin
        alu_f = '0;
        case (alufn)
            FN_ADD:  alu_f = op_a + op_b;
            FN_SUB:  alu_f = op_a - op_b;
            FN_PASS: alu_f = op_b;
            FN_OR:   alu_f = op_a | op_b;
            FN_AND:  alu_f = op_a & op_b;
            FN_XOR:  alu_f = op_a ^ op_b;
            FN_SLT:  alu_f = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            FN_SLTU: alu_f = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            default: alu_f = '0;
        endcase
    end

    // One-bit step of the iterative shifter
    always_comb begin
        acc_nxt = acc;
        case (styp)
            ST_SLL:  acc_nxt = {acc[XLEN-2:0], 1'b0};
            ST_SRL:  acc_nxt = {1'b0, acc[XLEN-1:1]};
            ST_SRA:  acc_nxt = {acc[XLEN-1], acc[XLEN-1:1]};
            default: acc_nxt = acc;
        endcase
    end

    // Sequencer FSM with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            result     <= '0;
            acc        <= '0;
            cnt        <= '0;
            styp       <= ST_SLL;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (is_shift && (shamt != '0)) begin
                            acc   <= op_a;
                            cnt   <= shamt;
                            styp  <= alufn[1:0];
                            state <= SHIFT;
                        end else begin
                            // zero-length shift degenerates to a pass of op_a
                            result     <= is_shift ? op_a : alu_f;
                            resp_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == 1) begin
                        result     <= acc_nxt;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // Branch-compare flag, only meaningful while a response is presented
    assign zero = resp_valid && (result == '0);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl: the driver pushes the expected responses,
// and the monitor pops and compares them whenever resp_valid is high.
module tb_alu_seq_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid;
    logic            req_ready;
    logic [3:0]      alufn;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
        int              acc_cyc;
        string           name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   first = 1'b1;

    alu_seq_ctrl #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .alufn(alufn), .op_a(op_a), .op_b(op_b), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .result(result), .zero(zero), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every presented response against the queue head
    always @(negedge clk) begin
        if (rst) begin
            first = 1'b1;
        end else if (resp_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got result %h expected no response", result);
            end else begin
                chk({q[0].name, "_result"}, result, q[0].res);
                chk({q[0].name, "_zero"}, {31'b0, zero}, {31'b0, (q[0].res == 0)});
                chk({q[0].name, "_req_ready"}, {31'b0, req_ready}, 32'd0);
                if (first) chk({q[0].name, "_latency"}, cyc - q[0].acc_cyc + 1, q[0].lat);
                first = 1'b0;
                if (resp_ready) begin
                    void'(q.pop_front());
                    first = 1'b1;
                end
            end
        end
    end

    // Drive one request; push an expectation when a response is due.
    // Operands are scrambled after accept to show they are ignored.
    task automatic issue(input string name, input logic [3:0] fn, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                         input int lat, input bit expect_resp, input bit wait_done);
        exp_t e;
        int n;
        req_valid = 1'b1; alufn = fn; op_a = a; op_b = b;
        n = 0;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL %s_accept_timeout: req_ready %0b expected 1", name, req_ready);
        end
        @(posedge clk); #1;
        e.res = exp; e.lat = lat; e.acc_cyc = cyc; e.name = name;
        if (expect_resp) q.push_back(e);
        req_valid = 1'b0;
        alufn = 4'b0001; op_a = 32'hDEADBEEF; op_b = 32'h0000001F;
        if (wait_done) begin
            n = 0;
            while (busy && n < 200) begin
                @(posedge clk); #1; n++;
            end
            if (busy) begin
                checks++; errors++;
                $display("FAIL %s_done_timeout: busy %0b expected 0", name, busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b1; alufn = 4'b0000; op_a = 32'd1; op_b = 32'd1;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; req_valid = 1'b0;
        // reset state
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_result", result, 32'd0);

        issue("add", 4'b0000, 32'd5, 32'd7, 32'd12, 1, 1, 1);
        issue("sub_zero", 4'b0001, 32'd9, 32'd9, 32'd0, 1, 1, 1);
        issue("sub_wrap", 4'b0001, 32'd0, 32'd1, 32'hFFFFFFFF, 1, 1, 1);
        issue("sll4", 4'b1000, 32'd1, 32'd4, 32'h10, 5, 1, 1);
        issue("srl4", 4'b1001, 32'hF0, 32'h24, 32'h0F, 5, 1, 1);
        issue("sra31", 4'b1010, 32'h80000000, 32'd31, 32'hFFFFFFFF, 32, 1, 1);
        issue("srl31", 4'b1001, 32'h80000000, 32'd31, 32'h00000001, 32, 1, 1);
        issue("sll_hi_b", 4'b1000, 32'h3, 32'hFFFFFFE3, 32'h18, 4, 1, 1);
        issue("sll0", 4'b1000, 32'h0000ABCD, 32'd0, 32'h0000ABCD, 1, 1, 1);
        issue("sra0", 4'b1010, 32'h80000001, 32'h00000100, 32'h80000001, 1, 1, 1);
        issue("slt", 4'b1101, 32'hFFFFFFFF, 32'd1, 32'd1, 1, 1, 1);
        issue("sltu", 4'b1111, 32'hFFFFFFFF, 32'd1, 32'd0, 1, 1, 1);
        issue("pass", 4'b0011, 32'hFFFFFFFF, 32'h12345000, 32'h12345000, 1, 1, 1);
        issue("or", 4'b0100, 32'hF0F00000, 32'h0000000F, 32'hF0F0000F, 1, 1, 1);
        issue("and", 4'b0101, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1, 1, 1);
        issue("xor", 4'b0111, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1, 1, 1);
        issue("undef", 4'b0110, 32'h12345678, 32'h1, 32'd0, 1, 1, 1);

        // backpressure: hold the response in DONE for 3 cycles
        resp_ready = 1'b0;
        issue("bp_add", 4'b0000, 32'd100, 32'd23, 32'd123, 1, 1, 0);
        repeat (3) @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_req_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_release_resp_valid", {31'b0, resp_valid}, 32'd0);

        // reset in the 3rd SHIFT cycle of SLL by 10 drops the response
        issue("abort_sll", 4'b1000, 32'd1, 32'd10, 32'd0, 11, 0, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_resp", {31'b0, resp_valid}, 32'd0);
        issue("post_abort_add", 4'b0000, 32'd40, 32'd2, 32'd42, 1, 1, 1);

        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
